// File: rtl/cpu_rf_pkg.sv
// Shared sizing helpers and constants for the register file and its read ports.
// Pure declarations; no logic, no latency, no flow control.
package cpu_rf_pkg;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int addr_w(input int num_regs);
      return (clog2(num_regs) < 1) ? 1 : clog2(num_regs);
   endfunction

   localparam int RF_DATA_W   = 16;
   localparam int RF_NUM_REGS = 8;
   localparam int ADDR_W      = addr_w(RF_NUM_REGS);
   localparam int BE_W        = RF_DATA_W / 8;
   localparam int RF_ZERO_IDX = 0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register mux, byte-wise write bypass and busy flag.
// Latency 0; no backpressure (pure combinational view of storage and scoreboard).
module rf_read_port
   import cpu_rf_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int NUM_REGS = 8,
   parameter  int ZERO_REG = 1,
   localparam int AW       = addr_w(NUM_REGS),
   localparam int BW       = DATA_W / 8
) (
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
   input  logic [NUM_REGS-1:0]             pending,
   input  logic                            wr_en,
   input  logic [AW-1:0]                   wr_addr,
   input  logic [BW-1:0]                   wr_be,
   input  logic [DATA_W-1:0]               wr_data,
   input  logic [AW-1:0]                   rd_addr,
   output logic [DATA_W-1:0]               rd_data,
   output logic                            busy
);

   localparam logic [AW:0] NUM_L = (AW+1)'(NUM_REGS);

   logic              in_range;
   logic              is_zero;
   logic              hit;
   logic [DATA_W-1:0] stored;

   assign in_range = ({1'b0, rd_addr} < NUM_L);
   assign is_zero  = (ZERO_REG != 0) && (rd_addr == AW'(RF_ZERO_IDX));
   assign hit      = wr_en && (wr_addr == rd_addr);

   always_comb begin
      stored  = '0;
      rd_data = '0;
      busy    = 1'b0;
      if (in_range && !is_zero) begin
         stored = regs[rd_addr];
         for (int b = 0; b < BW; b++) begin
            rd_data[8*b +: 8] = (hit && wr_be[b]) ? wr_data[8*b +: 8] : stored[8*b +: 8];
         end
         // A writeback landing this cycle already counts as released.
         busy = pending[rd_addr] && !hit;
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with byte-enabled writeback, two bypassing read ports and a pending scoreboard.
// Reads latency 0, writes/reservations take effect at the edge; no backpressure, always accepted.
module reg_file_sb
   import cpu_rf_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int NUM_REGS = 8,
   parameter  int ZERO_REG = 1,
   localparam int AW       = addr_w(NUM_REGS),
   localparam int BW       = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [BW-1:0]     wr_be,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   output logic              busy_a,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              busy_b,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr
);

   localparam logic [AW:0] NUM_L = (AW+1)'(NUM_REGS);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [NUM_REGS-1:0]             pending;
   logic [NUM_REGS-1:0]             pending_nxt;
   logic                            wr_ok;
   logic                            rsv_ok;
   logic                            wr_fwd;

   assign wr_ok  = wr_en && ({1'b0, wr_addr} < NUM_L)
                   && !((ZERO_REG != 0) && (wr_addr == AW'(RF_ZERO_IDX)));
   assign rsv_ok = rsv_en && ({1'b0, rsv_addr} < NUM_L)
                   && !((ZERO_REG != 0) && (rsv_addr == AW'(RF_ZERO_IDX)));
   // Bypass is suppressed while reset is held so reads show the cleared state.
   assign wr_fwd = wr_en && rst_n;

   always_comb begin
      pending_nxt = pending;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rsv_ok && (rsv_addr == AW'(i))) begin
            pending_nxt[i] = 1'b1;
         end else if (wr_ok && (wr_addr == AW'(i))) begin
            pending_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs    <= '0;
         pending <= '0;
      end else begin
         pending <= pending_nxt;
         for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < BW; b++) begin
               if (wr_ok && (wr_addr == AW'(i)) && wr_be[b]) begin
                  regs[i][8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   rf_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_port_a (
      .regs    (regs),
      .pending (pending),
      .wr_en   (wr_fwd),
      .wr_addr (wr_addr),
      .wr_be   (wr_be),
      .wr_data (wr_data),
      .rd_addr (rd_addr_a),
      .rd_data (rd_data_a),
      .busy    (busy_a)
   );

   rf_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_port_b (
      .regs    (regs),
      .pending (pending),
      .wr_en   (wr_fwd),
      .wr_addr (wr_addr),
      .wr_be   (wr_be),
      .wr_data (wr_data),
      .rd_addr (rd_addr_b),
      .rd_data (rd_data_b),
      .busy    (busy_b)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: 8-entry instance plus a 6-entry instance for out-of-range indices.
module tb_reg_file_sb;

   logic        clk;
   logic        rst_n;

   logic        wr_en, rsv_en;
   logic [2:0]  wr_addr, rd_addr_a, rd_addr_b, rsv_addr;
   logic [1:0]  wr_be;
   logic [15:0] wr_data;
   logic [15:0] rd_data_a, rd_data_b;
   logic        busy_a, busy_b;

   logic        w2_en, r2_en;
   logic [2:0]  w2_addr, a2_addr, b2_addr, r2_addr;
   logic [1:0]  w2_be;
   logic [15:0] w2_data;
   logic [15:0] d2_a, d2_b;
   logic        bz2_a, bz2_b;

   int vecs = 0;
   int errs = 0;

   reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_be     (wr_be),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_data_a (rd_data_a),
      .busy_a    (busy_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_b (rd_data_b),
      .busy_b    (busy_b),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr)
   );

   reg_file_sb #(.DATA_W(16), .NUM_REGS(6), .ZERO_REG(1)) dut6 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (w2_en),
      .wr_addr   (w2_addr),
      .wr_be     (w2_be),
      .wr_data   (w2_data),
      .rd_addr_a (a2_addr),
      .rd_data_a (d2_a),
      .busy_a    (bz2_a),
      .rd_addr_b (b2_addr),
      .rd_data_b (d2_b),
      .busy_b    (bz2_b),
      .rsv_en    (r2_en),
      .rsv_addr  (r2_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
   endtask

   task automatic idle();
      wr_en = 1'b0; rsv_en = 1'b0; wr_be = 2'b00; wr_data = 16'h0;
   endtask

   initial begin
      rst_n = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
      rd_addr_a = '0; rd_addr_b = '0; rsv_en = 1'b0; rsv_addr = '0;
      w2_en = 1'b0; w2_addr = '0; w2_be = '0; w2_data = '0;
      a2_addr = '0; b2_addr = '0; r2_en = 1'b0; r2_addr = '0;
      #2 rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // Reset: pending r1 and a write to r3 are both discarded by reset.
      rsv_en = 1'b1; rsv_addr = 3'd1;
      tick();
      rsv_en = 1'b0; rd_addr_b = 3'd1;
      #1 chk("rsv_r1_busy", busy_b, 1);
      wr(3'd3, 16'hBEEF, 2'b11); rd_addr_a = 3'd3;
      #1 rst_n = 1'b0;
      #1 chk("rst_rd_a", rd_data_a, 16'h0000);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_busy_b", busy_b, 0);
      tick();
      idle(); rst_n = 1'b1;
      tick();
      chk("post_rst_r3", rd_data_a, 16'h0000);
      chk("post_rst_busy_a", busy_a, 0);
      chk("post_rst_busy_r1", busy_b, 0);

      // Zero register ignores writes, bypass and reservations.
      wr(3'd0, 16'h1234, 2'b11); rsv_en = 1'b1; rsv_addr = 3'd0; rd_addr_a = 3'd0;
      #1 chk("r0_bypass", rd_data_a, 16'h0000);
      tick();
      idle();
      #1 chk("r0_stored", rd_data_a, 16'h0000);
      chk("r0_busy", busy_a, 0);

      // Byte enables.
      wr(3'd2, 16'hAAAA, 2'b11); rd_addr_a = 3'd2;
      tick();
      wr(3'd2, 16'h5511, 2'b01);
      #1 chk("be01_bypass", rd_data_a, 16'hAA11);
      tick();
      idle();
      #1 chk("be01_stored", rd_data_a, 16'hAA11);
      wr(3'd2, 16'h5511, 2'b00);
      #1 chk("be00_bypass", rd_data_a, 16'hAA11);
      tick();
      idle();
      #1 chk("be00_stored", rd_data_a, 16'hAA11);
      chk("unreserved_busy", busy_a, 0);

      // Byte-wise bypass on both ports.
      wr(3'd5, 16'h0F0F, 2'b11);
      tick();
      wr(3'd5, 16'h1234, 2'b10); rd_addr_a = 3'd5; rd_addr_b = 3'd5;
      #1 chk("bypass_a", rd_data_a, 16'h120F);
      chk("bypass_b", rd_data_b, 16'h120F);
      tick();
      idle();
      #1 chk("bypass_stored_a", rd_data_a, 16'h120F);
      chk("bypass_stored_b", rd_data_b, 16'h120F);

      // Scoreboard: reserve r4 in cycle 1, release in cycle 5.
      rsv_en = 1'b1; rsv_addr = 3'd4; rd_addr_a = 3'd4;
      #1 chk("sb_c1_busy", busy_a, 0);
      tick();
      rsv_en = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         #1 chk($sformatf("sb_c%0d_busy", c), busy_a, 1);
         tick();
      end
      wr(3'd4, 16'h0044, 2'b11);
      #1 chk("sb_c5_busy", busy_a, 0);
      chk("sb_c5_data", rd_data_a, 16'h0044);
      tick();
      idle();
      #1 chk("sb_after_busy", busy_a, 0);
      chk("sb_after_data", rd_data_a, 16'h0044);

      // Collision: set wins over same-cycle release.
      rsv_en = 1'b1; rsv_addr = 3'd6; rd_addr_b = 3'd6;
      tick();
      rsv_en = 1'b0;
      #1 chk("col_pending", busy_b, 1);
      rsv_en = 1'b1; wr(3'd6, 16'h6666, 2'b11);
      #1 chk("col_comb_busy", busy_b, 0);
      tick();
      idle();
      #1 chk("col_busy_after", busy_b, 1);
      chk("col_data", rd_data_b, 16'h6666);
      // Re-reserving a pending register does not count; one release clears it.
      rsv_en = 1'b1; rsv_addr = 3'd6;
      tick();
      idle(); wr(3'd6, 16'h6667, 2'b01);
      tick();
      idle();
      #1 chk("rersv_cleared", busy_b, 0);
      chk("rersv_data", rd_data_b, 16'h6667);

      // Out-of-range index on the 6-entry instance.
      w2_en = 1'b1; w2_addr = 3'd5; w2_data = 16'h5555; w2_be = 2'b11;
      tick();
      w2_addr = 3'd7; w2_data = 16'h7777; r2_en = 1'b1; r2_addr = 3'd7;
      a2_addr = 3'd7; b2_addr = 3'd5;
      #1 chk("oor_comb_rd", d2_a, 16'h0000);
      chk("oor_comb_busy", bz2_a, 0);
      tick();
      w2_en = 1'b0; r2_en = 1'b0; w2_be = 2'b00;
      #1 chk("oor_rd", d2_a, 16'h0000);
      chk("oor_busy", bz2_a, 0);
      chk("oor_r5_kept", d2_b, 16'h5555);
      chk("oor_r5_busy", bz2_b, 0);
      b2_addr = 3'd6;
      #1 chk("oor_r6_rd", d2_b, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: observed no finish, expected finish before 50000");
      $fatal(1, "timeout");
   end

endmodule
